// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (IF) and load/store (LS), one transaction in flight.
// Define ARB_FAIRNESS_EN to force an IF grant after STARVE_MAX consecutive IF losses.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
`ifdef ARB_FAIRNESS_EN
    , parameter int STARVE_MAX = 4
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t     state, state_nxt;
    logic [2:0] lat_cnt;
    logic       own_ls;
    logic       last_wait;
    logic       arb_en;
    logic       force_if;
    logic       ls_win;
    logic       if_win;
    logic       any_gnt;

    // Arbitration happens when idle or in the response cycle, so back-to-back accesses lose no cycle.
    assign last_wait = (state == WAIT) && (lat_cnt == 3'(MEM_LAT));
    assign arb_en    = !reset && ((state == IDLE) || last_wait);

`ifdef ARB_FAIRNESS_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_cnt;

    assign force_if = (starve_cnt == SW'(STARVE_MAX)) && if_req && ls_req;

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (arb_en) begin
            if (!if_req || if_win)
                starve_cnt <= '0;
            else if (ls_win)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    assign ls_win  = arb_en && ls_req && !force_if;
    assign if_win  = arb_en && if_req && !ls_win;
    assign any_gnt = ls_win || if_win;

    assign ls_gnt    = ls_win;
    assign if_gnt    = if_win;
    assign ls_rvalid = !reset && last_wait && own_ls;
    assign if_rvalid = !reset && last_wait && !own_ls;
    assign ls_rdata  = mem_rdata;
    assign if_rdata  = mem_rdata;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_gnt) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (last_wait) state_nxt = any_gnt ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Port fields are captured at grant, so mem_en/we/size are high only in the ISSUE cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            own_ls    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_size  <= 2'b00;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state    <= state_nxt;
            mem_en   <= any_gnt;
            mem_we   <= ls_win && ls_we;
            mem_size <= ls_win ? ls_size : (if_win ? 2'b10 : 2'b00);
            if (any_gnt) begin
                own_ls    <= ls_win;
                mem_addr  <= ls_win ? ls_addr : if_addr;
                mem_wdata <= ls_win ? ls_wdata : '0;
            end
            if (state == ISSUE)
                lat_cnt <= 3'd1;
            else if (last_wait)
                lat_cnt <= '0;
            else if (state == WAIT)
                lat_cnt <= lat_cnt + 3'd1;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified instruction/data memory between the fetch stage (IF) and the load/store path (LS) of the RV32I core. Accepts one request at a time, drives the memory port with registered signals, counts out the fixed memory read latency and returns the response to the winning requester. Sits between fetch/LSU and the memory model; the control decoder's load/store classification feeds `ls_req`/`ls_we`.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 1, cycles from the `mem_en` cycle to `mem_rdata` valid; legal range 1..7
- `STARVE_MAX`, 4, consecutive IF losses before forced IF grant (fairness build only)

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `if_req` in 1: fetch request; held until `if_gnt`
- `if_addr` in ADDR_W: fetch address
- `if_gnt` out 1: request accepted this cycle
- `if_rvalid` out 1: one-cycle pulse, `if_rdata` valid
- `if_rdata` out DATA_W: instruction word
- `ls_req` in 1: load/store request; held until `ls_gnt`
- `ls_we` in 1: 1 = store
- `ls_size` in 2: 00 byte, 01 half, 10 word
- `ls_addr` in ADDR_W, `ls_wdata` in DATA_W
- `ls_gnt` out 1, `ls_rvalid` out 1, `ls_rdata` out DATA_W: as IF; `ls_rvalid` also acks stores
- `mem_en`, `mem_we` out 1; `mem_size` out 2; `mem_addr` out ADDR_W; `mem_wdata` out DATA_W: registered memory port
- `mem_rdata` in DATA_W: memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT. One transaction outstanding at most; owner flag `own_ls` records the winner.
- Arbitration (IDLE, or last WAIT cycle): if any req, assert exactly one `*_gnt` combinationally; LS wins over IF when both are high. Capture address/data/we/size of the winner; next state ISSUE.
- ISSUE: `mem_en`=1 for exactly one cycle with captured fields. IF always `mem_we`=0, `mem_size`=10, `mem_wdata`=0. Latency counter loads 1; next state WAIT.
- WAIT: counter increments each cycle; when counter == MEM_LAT, pulse owner's `*_rvalid`, then arbitrate again in the same cycle (back-to-back) or go to IDLE.
- `*_rdata` = `mem_rdata` passthrough; only meaningful while the matching `*_rvalid` is high. Non-owner `rvalid` always 0.
- Requesters must not drop `req` before `gnt`; behaviour undefined otherwise.
- Counter width 3 bits; no wrap occurs because MEM_LAT ≤ 7.

## Timing
- Reset values: state IDLE; all `gnt`, `rvalid`, `mem_en`, `mem_we` = 0; `mem_addr`, `mem_wdata`, `mem_size`, counter, starve counter = 0; `own_ls` = 0.
- Reset asserted mid-transaction: next cycle in IDLE, in-flight response dropped, no `rvalid` issued for it.
- Grant in cycle T → `mem_en` at T+1 → `rvalid` at T+1+MEM_LAT.
- Back-to-back: new grant allowed in the `rvalid` cycle; throughput one access per MEM_LAT+1 cycles.
- No request pending in IDLE: all outputs hold reset-like values except `mem_addr`/`mem_wdata`, which hold last value.

## Configuration
- `ARB_FAIRNESS_EN` defined: starve counter increments on every arbitration where `if_req`=1 and LS wins; clears on IF grant or when `if_req`=0 at arbitration. When counter == STARVE_MAX and both req high, IF wins and counter clears.
- Not defined: strict LS priority; starve counter and `STARVE_MAX` absent from logic.

## Test plan
- Reset, then `if_req`=1 `if_addr`=0x0100_0000, MEM_LAT=1 → `if_gnt` at T, `mem_en`=1 `mem_addr`=0x0100_0000 `mem_size`=10 at T+1, `if_rvalid`=1 with `if_rdata`=memory word at T+2.
- Both req at T, `ls_we`=1 `ls_addr`=0x0100_0040 `ls_wdata`=0xDEAD_BEEF `ls_size`=10 → `ls_gnt` at T, store on port at T+1, `ls_rvalid` at T+2, `if_gnt` at T+2, `if_rvalid` at T+4.
- MEM_LAT=3, continuous `if_req` → `mem_en` pulses every 4 cycles, `if_rvalid` 3 cycles after each.
- `reset` high during WAIT of an LS load → no `ls_rvalid`, all outputs 0 next cycle, IF request granted first cycle after reset drops.
- With `ARB_FAIRNESS_EN`, STARVE_MAX=4, both req held high → 4 LS grants then 1 IF grant, repeating; without macro → IF never granted.
- Byte load `ls_size`=00 `ls_addr`=0x0100_0003 → `mem_size`=00, `mem_addr`=0x0100_0003, `mem_we`=0 in ISSUE cycle.
